// File: rtl/pipeline_hazard_ctl.sv
// rtl/pipeline_hazard_ctl.sv - hazard, stall and forwarding scheduler for the 5-stage pipeline
// Decides register loads/flushes, EX operand forwarding and data-memory wait sequencing.
module pipeline_hazard_ctl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt_src,
  input  logic        mem_regwrite,
  input  logic        wb_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        mem_branch,
  input  logic        mem_zero,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic        pc_ld,
  output logic        ifid_ld,
  output logic        idex_ld,
  output logic        exmem_ld,
  output logic        memwb_ld,
  output logic        pc_src,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_err
);

  localparam logic [0:0]  RUN       = 1'b0;
  localparam logic [0:0]  MEM_WAIT  = 1'b1;
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  logic [0:0]  state;
  logic [15:0] wait_cnt;
  logic        hold;
  logic        timeout;
  logic        branch_taken;
  logic        load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       m_we,
    input logic [4:0] m_rd,
    input logic       w_we,
    input logic [4:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && (m_rd != 5'd0) && (m_rd == src)) begin
      sel = 2'b10;
    end else if (w_we && (w_rd != 5'd0) && (w_rd == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign branch_taken = mem_branch & mem_zero;
  assign load_use     = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

  // In MEM_WAIT the last permitted wait cycle releases the pipeline even without ready.
  assign timeout = (state == MEM_WAIT) & ~dmem_ready & (wait_cnt == WAIT_LAST);
  assign hold    = (state == RUN) ? (mem_access & ~dmem_ready)
                                  : (~dmem_ready & (wait_cnt != WAIT_LAST));

  always_comb begin
    pc_ld       = 1'b0;
    ifid_ld     = 1'b0;
    idex_ld     = 1'b0;
    exmem_ld    = 1'b0;
    memwb_ld    = 1'b0;
    pc_src      = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (rst && !hold) begin
      pc_ld    = 1'b1;
      ifid_ld  = 1'b1;
      idex_ld  = 1'b1;
      exmem_ld = 1'b1;
      memwb_ld = 1'b1;
      if (branch_taken) begin
        pc_src      = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_ld      = 1'b0;
        ifid_ld    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst) begin
      fwd_a = fwd_sel(ex_rs, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
      fwd_b = fwd_sel(ex_rt_src, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= 16'd0;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
      mem_err   <= 1'b0;
    end else begin
      if (state == RUN) begin
        if (hold) begin
          state    <= MEM_WAIT;
          wait_cnt <= 16'd0;
        end
      end else begin
        if (hold) begin
          wait_cnt <= wait_cnt + 16'd1;
        end else begin
          state    <= RUN;
          wait_cnt <= 16'd0;
          if (timeout) begin
            mem_err <= 1'b1;
          end
        end
      end
      if (!pc_ld && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (pc_src && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// tb/tb_pipeline_hazard_ctl.sv - self-checking bench for pipeline_hazard_ctl
module tb_pipeline_hazard_ctl;
  localparam int TMO = 4;

  typedef struct packed {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt_src;
    logic       mem_regwrite;
    logic [4:0] mem_rd;
    logic       wb_regwrite;
    logic [4:0] wb_rd;
    logic       mem_branch;
    logic       mem_zero;
    logic       mem_access;
    logic       dmem_ready;
  } in_t;

  typedef struct packed {
    logic [4:0] ld;
    logic       pc_src;
    logic [2:0] flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
  } out_t;

  typedef struct {
    string nm;
    in_t   i;
    out_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  in_t  cur;
  out_t act;

  logic        pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, pc_src;
  logic        ifid_flush, idex_flush, exmem_flush, mem_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  bit m_wait;
  int m_waited;
  bit m_err;
  int m_stall;
  int m_flush;

  always #5 clk = ~clk;

  pipeline_hazard_ctl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .id_rs(cur.id_rs), .id_rt(cur.id_rt),
    .ex_memread(cur.ex_memread), .ex_rt(cur.ex_rt),
    .ex_rs(cur.ex_rs), .ex_rt_src(cur.ex_rt_src),
    .mem_regwrite(cur.mem_regwrite), .wb_regwrite(cur.wb_regwrite),
    .mem_rd(cur.mem_rd), .wb_rd(cur.wb_rd),
    .mem_branch(cur.mem_branch), .mem_zero(cur.mem_zero),
    .mem_access(cur.mem_access), .dmem_ready(cur.dmem_ready),
    .pc_ld(pc_ld), .ifid_ld(ifid_ld), .idex_ld(idex_ld),
    .exmem_ld(exmem_ld), .memwb_ld(memwb_ld), .pc_src(pc_src),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
  );

  assign act = {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, pc_src,
                ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b};

  // Argument order: rs, rt, memread, ex_rt, ex_rs, ex_rt_src, mem_we, mem_rd, wb_we, wb_rd, br, zero, access, ready
  function automatic in_t mk_in(int rs, int rt, int mrd_ld, int lrt, int ers, int erts,
                                int mwe, int mrd, int wwe, int wrd, int br, int z,
                                int acc, int rdy);
    in_t v;
    v.id_rs = 5'(rs);         v.id_rt = 5'(rt);
    v.ex_memread = 1'(mrd_ld); v.ex_rt = 5'(lrt);
    v.ex_rs = 5'(ers);        v.ex_rt_src = 5'(erts);
    v.mem_regwrite = 1'(mwe); v.mem_rd = 5'(mrd);
    v.wb_regwrite = 1'(wwe);  v.wb_rd = 5'(wrd);
    v.mem_branch = 1'(br);    v.mem_zero = 1'(z);
    v.mem_access = 1'(acc);   v.dmem_ready = 1'(rdy);
    return v;
  endfunction

  function automatic out_t mk_out(int ld, int ps, int fl, int fa, int fb);
    out_t o;
    o.ld = 5'(ld); o.pc_src = 1'(ps); o.flush = 3'(fl);
    o.fwd_a = 2'(fa); o.fwd_b = 2'(fb);
    return o;
  endfunction

  function automatic vec_t mk_vec(string nm, in_t i, out_t e);
    vec_t v;
    v.nm = nm; v.i = i; v.e = e;
    return v;
  endfunction

  function automatic logic [1:0] fwd_of(in_t i, logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (i.mem_regwrite && i.mem_rd == src) return 2'b10;
    if (i.wb_regwrite && i.wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Reference: a wait either ends on ready or on its TMO-th cycle in the wait state.
  function automatic out_t model_out(in_t i);
    out_t o;
    bit   held;
    o = '0;
    if (!m_wait) held = i.mem_access && !i.dmem_ready;
    else         held = !i.dmem_ready && (m_waited + 1 < TMO);
    if (held) begin
      o.ld = 5'b00000;
    end else if (i.mem_branch && i.mem_zero) begin
      o.ld = 5'b11111; o.pc_src = 1'b1; o.flush = 3'b111;
    end else if (i.ex_memread && i.ex_rt != 5'd0 && (i.ex_rt == i.id_rs || i.ex_rt == i.id_rt)) begin
      o.ld = 5'b00111; o.flush = 3'b010;
    end else begin
      o.ld = 5'b11111;
    end
    o.fwd_a = fwd_of(i, i.ex_rs);
    o.fwd_b = fwd_of(i, i.ex_rt_src);
    return o;
  endfunction

  task automatic model_step(input in_t i, input out_t o);
    if (!m_wait) begin
      if (i.mem_access && !i.dmem_ready) begin
        m_wait = 1'b1;
        m_waited = 0;
      end
    end else if (!i.dmem_ready && (m_waited + 1 < TMO)) begin
      m_waited++;
    end else begin
      if (!i.dmem_ready) m_err = 1'b1;
      m_wait = 1'b0;
    end
    if (!o.ld[4] && m_stall < 65535) m_stall++;
    if (o.pc_src && m_flush < 65535) m_flush++;
  endtask

  task automatic model_reset();
    m_wait = 1'b0; m_waited = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  task automatic chk_out(input string nm, input out_t e);
    tests++;
    if (act !== e) begin
      fails++;
      $display("FAIL %s: got %b required %b", nm, act, e);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] a, input logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, a, e);
    end
  endtask

  // Called just after a rising edge; applies one cycle and checks it before the next edge.
  task automatic cycle(input in_t i, input out_t e, input string nm);
    cur = i;
    @(negedge clk);
    chk_out(nm, e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    cur = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    in_t  m;
    out_t o;
    out_t run_o;
    out_t idle_o;
    out_t br_o;
    int   exp_stall;
    int   exp_flush;

    run_o  = mk_out(5'b11111, 0, 0, 0, 0);
    idle_o = mk_out(0, 0, 0, 0, 0);
    br_o   = mk_out(5'b11111, 1, 3'b111, 0, 0);

    vt.push_back(mk_vec("idle",        mk_in(0,0,0,0,0,0,0,0,0,0,0,0,0,0), run_o));
    vt.push_back(mk_vec("exmem_both",  mk_in(0,0,0,0,2,2,1,2,0,0,0,0,0,0), mk_out(5'b11111,0,0,2,2)));
    vt.push_back(mk_vec("memwb_a",     mk_in(0,0,0,0,2,4,0,0,1,2,0,0,0,0), mk_out(5'b11111,0,0,1,0)));
    vt.push_back(mk_vec("exmem_prio",  mk_in(0,0,0,0,2,2,1,2,1,2,0,0,0,0), mk_out(5'b11111,0,0,2,2)));
    vt.push_back(mk_vec("split_fwd",   mk_in(0,0,0,0,3,5,1,5,1,3,0,0,0,0), mk_out(5'b11111,0,0,1,2)));
    vt.push_back(mk_vec("r0_no_fwd",   mk_in(0,0,0,0,0,0,1,0,1,0,0,0,0,0), run_o));
    vt.push_back(mk_vec("no_regwrite", mk_in(0,0,0,0,2,2,0,2,0,2,0,0,0,0), run_o));
    vt.push_back(mk_vec("loaduse_rs",  mk_in(2,4,1,2,0,0,0,0,0,0,0,0,0,0), mk_out(5'b00111,0,3'b010,0,0)));
    vt.push_back(mk_vec("loaduse_rt",  mk_in(4,2,1,2,0,0,0,0,0,0,0,0,0,0), mk_out(5'b00111,0,3'b010,0,0)));
    vt.push_back(mk_vec("load_r0",     mk_in(0,0,1,0,0,0,0,0,0,0,0,0,0,0), run_o));
    vt.push_back(mk_vec("no_load",     mk_in(2,0,0,2,0,0,0,0,0,0,0,0,0,0), run_o));
    vt.push_back(mk_vec("branch",      mk_in(0,0,0,0,0,0,0,0,0,0,1,1,0,0), br_o));
    vt.push_back(mk_vec("branch_nt",   mk_in(0,0,0,0,0,0,0,0,0,0,1,0,0,0), run_o));
    vt.push_back(mk_vec("zero_only",   mk_in(0,0,0,0,0,0,0,0,0,0,0,1,0,0), run_o));
    vt.push_back(mk_vec("br_loaduse",  mk_in(2,0,1,2,0,0,0,0,0,0,1,1,0,0), br_o));
    vt.push_back(mk_vec("acc_ready",   mk_in(0,0,0,0,0,0,0,0,0,0,0,0,1,1), run_o));
    vt.push_back(mk_vec("br_fwd",      mk_in(0,0,0,0,2,0,1,2,0,0,1,1,0,0), mk_out(5'b11111,1,3'b111,2,0)));

    // Reset state, with inputs that would otherwise forward, branch and stall
    cur = mk_in(2,0,1,2,2,2,1,2,1,2,1,1,1,0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset_outputs", idle_o);
    chk16("reset_stall_cnt", stall_cnt, 16'd0);
    chk16("reset_flush_cnt", flush_cnt, 16'd0);
    chk16("reset_mem_err", {15'd0, mem_err}, 16'd0);
    cur = '0;
    rst = 1'b1;

    exp_stall = 0;
    exp_flush = 0;
    foreach (vt[k]) begin
      cycle(vt[k].i, vt[k].e, vt[k].nm);
      if (!vt[k].e.ld[4]) exp_stall++;
      if (vt[k].e.pc_src) exp_flush++;
    end
    chk16("table_stall_cnt", stall_cnt, 16'(exp_stall));
    chk16("table_flush_cnt", flush_cnt, 16'(exp_flush));

    // lw $2 then add $3,$2,$4: one bubble, then forward from EX_MEM
    reset_dut();
    cycle(mk_in(2,4,1,2,0,0,0,0,0,0,0,0,0,0), mk_out(5'b00111,0,3'b010,0,0), "lu_bubble");
    cycle(mk_in(0,0,0,0,2,4,1,2,0,0,0,0,0,0), mk_out(5'b11111,0,0,2,0), "lu_forward");
    chk16("lu_stall_cnt", stall_cnt, 16'd1);

    // Memory wait: ready low for 3 cycles, release on the 4th
    reset_dut();
    m = mk_in(0,0,0,0,0,0,0,0,0,0,0,0,1,0);
    for (int c = 0; c < 3; c++) cycle(m, idle_o, "memwait_hold");
    m.dmem_ready = 1'b1;
    cycle(m, run_o, "memwait_release");
    chk16("memwait_stall_cnt", stall_cnt, 16'd3);
    cycle(mk_in(0,0,0,0,0,0,0,0,0,0,0,0,0,0), run_o, "memwait_back_run");

    // Memory stall beats a branch; the branch resolves on the ready cycle
    reset_dut();
    m = mk_in(0,0,0,0,0,0,0,0,0,0,1,1,1,0);
    cycle(m, idle_o, "memwin_hold");
    m.dmem_ready = 1'b1;
    cycle(m, br_o, "memwin_branch");
    chk16("memwin_flush_cnt", flush_cnt, 16'd1);
    chk16("memwin_stall_cnt", stall_cnt, 16'd1);

    // Timeout: RUN stall cycle, 3 held wait cycles, forced release on the 4th wait cycle
    reset_dut();
    m = mk_in(0,0,0,0,0,0,0,0,0,0,0,0,1,0);
    for (int c = 0; c < 4; c++) cycle(m, idle_o, "tmo_hold");
    chk16("tmo_err_before", {15'd0, mem_err}, 16'd0);
    cycle(m, run_o, "tmo_release");
    chk16("tmo_err_set", {15'd0, mem_err}, 16'd1);
    chk16("tmo_stall_cnt", stall_cnt, 16'd4);
    cycle(mk_in(0,0,0,0,0,0,0,0,0,0,0,0,0,0), run_o, "tmo_after_run");
    cycle(mk_in(0,0,0,0,0,0,0,0,0,0,0,0,0,0), run_o, "tmo_after_run2");
    chk16("tmo_err_sticky", {15'd0, mem_err}, 16'd1);
    reset_dut();
    chk16("tmo_err_cleared", {15'd0, mem_err}, 16'd0);

    // Reset dropped mid-wait acts immediately
    reset_dut();
    m = mk_in(0,0,0,0,0,0,0,0,0,0,0,0,1,0);
    cycle(m, idle_o, "rstw_hold1");
    cycle(m, idle_o, "rstw_hold2");
    chk16("rstw_stall_before", stall_cnt, 16'd2);
    cur = mk_in(2,0,1,2,2,2,1,2,0,0,1,1,1,0);
    #2;
    rst = 1'b0;
    #1;
    chk_out("rstw_outputs_zero", idle_o);
    chk16("rstw_stall_async", stall_cnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    chk16("rstw_stall_after", stall_cnt, 16'd0);
    cycle(mk_in(0,0,0,0,0,0,0,0,0,0,0,0,0,0), run_o, "rstw_first_run");

    // Randomised traffic against the reference model
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      m.id_rs        = 5'($urandom_range(0, 3));
      m.id_rt        = 5'($urandom_range(0, 3));
      m.ex_memread   = 1'($urandom_range(0, 1));
      m.ex_rt        = 5'($urandom_range(0, 3));
      m.ex_rs        = 5'($urandom_range(0, 3));
      m.ex_rt_src    = 5'($urandom_range(0, 3));
      m.mem_regwrite = 1'($urandom_range(0, 1));
      m.mem_rd       = 5'($urandom_range(0, 3));
      m.wb_regwrite  = 1'($urandom_range(0, 1));
      m.wb_rd        = 5'($urandom_range(0, 3));
      m.mem_branch   = 1'($urandom_range(0, 1));
      m.mem_zero     = 1'($urandom_range(0, 1));
      m.mem_access   = ($urandom_range(0, 3) == 0);
      m.dmem_ready   = 1'($urandom_range(0, 1));
      cur = m;
      @(negedge clk);
      o = model_out(m);
      chk_out("rand_outputs", o);
      model_step(m, o);
      @(posedge clk);
      #1;
      chk16("rand_stall_cnt", stall_cnt, 16'(m_stall));
      chk16("rand_flush_cnt", flush_cnt, 16'(m_flush));
      chk16("rand_mem_err", {15'd0, mem_err}, {15'd0, m_err});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
